// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit path.
//   - tx_state_e      : 3-bit transmit FSM state encoding
//   - LCR_*           : bit positions inside the line control register
//   - TICKS_*         : 16x-baud ticks per bit (data / 1.5 stop / 2 stop)
//   - last_tick()     : converts a tick count into the terminal value of
//                       the 5-bit tick counter
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Line control register fields; WLS occupies [LCR_WLS+1:LCR_WLS].
  localparam int unsigned LCR_WLS = 0;
  localparam int unsigned LCR_STB = 2;
  localparam int unsigned LCR_PEN = 3;
  localparam int unsigned LCR_EPS = 4;
  localparam int unsigned LCR_SP  = 5;
  localparam int unsigned LCR_BC  = 6;

  localparam int unsigned TICKS_BIT     = 16;
  localparam int unsigned TICKS_STOP_15 = 24;
  localparam int unsigned TICKS_STOP_2  = 32;

  // The tick counter runs 0..N-1, so a bit of N ticks ends at N-1.
  function automatic logic [4:0] last_tick(input int unsigned ticks);
    return 5'(ticks - 32'd1);
  endfunction

endpackage

// File: rtl/uart_tx_parity.sv
// uart_tx_parity: combinational parity bit for one transmit character.
// Ports:
//   data   in  DATA_W  character as latched at frame start
//   wls    in  2       word length select (5 + wls bits are significant)
//   eps    in  1       even parity select
//   stick  in  1       stick parity (bit forced to ~eps)
//   parity out 1       parity bit to transmit
module uart_tx_parity
  import uart_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        wls,
  input  logic              eps,
  input  logic              stick,
  output logic              parity
);

  logic [DATA_W-1:0] mask;
  logic              xor_all;

  // Mask off bits above the word length, then pick even/odd/stick result.
  always_comb begin
    mask = '0;
    for (int i = 0; i < DATA_W; i++) begin
      mask[i] = (i < (5 + int'(wls)));
    end
    xor_all = ^(data & mask);
    if (stick) begin
      parity = ~eps;
    end else if (eps) begin
      parity = xor_all;
    end else begin
      parity = ~xor_all;
    end
  end

endmodule

// File: rtl/uart_tx_shifter.sv
// uart_tx_shifter: UART serial transmit stage. Pops characters from the
// transmit FIFO and sends each as start, 5-8 data bits (LSB first),
// optional parity and 1/1.5/2 stop bits, paced by a 16x baud tick.
// Build option: define UART_TX_PARITY_EN to compile in the parity bit and
// the PARITY state; without it lcr[5:3] are ignored.
// Ports:
//   clk         in  1        clock
//   nreset      in  1        asynchronous active-low reset
//   enable      in  1        one-cycle 16x baud tick
//   lcr         in  8        line control register (break bit is live)
//   fifo_data   in  DATA_W   FIFO head entry
//   fifo_count  in  COUNT_W  FIFO occupancy
//   fifo_pop    out 1        pop strobe, only in IDLE with data present
//   stx         out 1        serial output, idle high
//   tx_idle     out 1        high while no frame is in progress
module uart_tx_shifter
  import uart_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int COUNT_W = 5
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic               enable,
  input  logic [7:0]         lcr,
  input  logic [DATA_W-1:0]  fifo_data,
  input  logic [COUNT_W-1:0] fifo_count,
  output logic               fifo_pop,
  output logic               stx,
  output logic               tx_idle
);

  tx_state_e         state;
  tx_state_e         next_state;
  logic [DATA_W-1:0] shift;
  logic [4:0]        tick_cnt;
  logic [2:0]        bit_cnt;
  logic [1:0]        cfg_wls;
  logic              cfg_stb;
  logic              armed;
  logic [4:0]        last;
  logic              bit_done;
  logic              bit_val;

`ifdef UART_TX_PARITY_EN
  logic              cfg_pen;
  logic              cfg_eps;
  logic              cfg_sp;
  logic [DATA_W-1:0] data_hold;
  logic              parity_bit;
  logic              unused_lcr;

  assign unused_lcr = lcr[7];

  uart_tx_parity #(.DATA_W(DATA_W)) u_parity (
    .data   (data_hold),
    .wls    (cfg_wls),
    .eps    (cfg_eps),
    .stick  (cfg_sp),
    .parity (parity_bit)
  );
`else
  logic              unused_lcr;

  assign unused_lcr = ^{lcr[7], lcr[LCR_SP:LCR_PEN]};
`endif

  // Terminal tick for the current bit; only the stop bit can be longer.
  always_comb begin
    if ((state == ST_STOP) && cfg_stb) begin
      last = (cfg_wls == 2'd0) ? last_tick(TICKS_STOP_15) : last_tick(TICKS_STOP_2);
    end else begin
      last = last_tick(TICKS_BIT);
    end
  end

  assign bit_done = enable && (tick_cnt == last);

  // State register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; every non-idle transition waits for a completed bit.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (armed && (fifo_count != '0)) next_state = ST_START;
        else                             next_state = ST_IDLE;
      end
      ST_START: begin
        if (bit_done) next_state = ST_DATA;
        else          next_state = ST_START;
      end
      ST_DATA: begin
        if (bit_done && (bit_cnt == 3'd0)) begin
`ifdef UART_TX_PARITY_EN
          next_state = cfg_pen ? ST_PARITY : ST_STOP;
`else
          next_state = ST_STOP;
`endif
        end else begin
          next_state = ST_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_done) next_state = ST_STOP;
        else          next_state = ST_PARITY;
      end
`endif
      ST_STOP: begin
        if (bit_done) next_state = ST_IDLE;
        else          next_state = ST_STOP;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; break overrides the line level in any state.
  // armed keeps fifo_pop low while reset is held and for the first edge after.
  always_comb begin
    bit_val = 1'b1;
    case (state)
      ST_IDLE:   bit_val = 1'b1;
      ST_START:  bit_val = 1'b0;
      ST_DATA:   bit_val = shift[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: bit_val = parity_bit;
`endif
      ST_STOP:   bit_val = 1'b1;
      default:   bit_val = 1'b1;
    endcase
    stx      = lcr[LCR_BC] ? 1'b0 : bit_val;
    tx_idle  = (state == ST_IDLE);
    fifo_pop = (state == ST_IDLE) && armed && (fifo_count != '0);
  end

  // Datapath: frame load on pop, tick/bit counting and shifting on enable.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      armed     <= 1'b0;
      shift     <= '0;
      tick_cnt  <= 5'd0;
      bit_cnt   <= 3'd0;
      cfg_wls   <= 2'd0;
      cfg_stb   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      cfg_pen   <= 1'b0;
      cfg_eps   <= 1'b0;
      cfg_sp    <= 1'b0;
      data_hold <= '0;
`endif
    end else begin
      armed <= 1'b1;
      if (fifo_pop) begin
        shift    <= fifo_data;
        tick_cnt <= 5'd0;
        // Word length minus one: 5 + wls - 1.
        bit_cnt  <= 3'd4 + {1'b0, lcr[LCR_WLS+1:LCR_WLS]};
        cfg_wls  <= lcr[LCR_WLS+1:LCR_WLS];
        cfg_stb  <= lcr[LCR_STB];
`ifdef UART_TX_PARITY_EN
        cfg_pen   <= lcr[LCR_PEN];
        cfg_eps   <= lcr[LCR_EPS];
        cfg_sp    <= lcr[LCR_SP];
        data_hold <= fifo_data;
`endif
      end else if (enable && (state != ST_IDLE)) begin
        if (bit_done) begin
          tick_cnt <= 5'd0;
          if (state == ST_DATA) begin
            shift   <= {1'b0, shift[DATA_W-1:1]};
            bit_cnt <= bit_cnt - 3'd1;
          end
        end else begin
          tick_cnt <= tick_cnt + 5'd1;
        end
      end
    end
  end

endmodule
